apb_rr_master: RTL

- Sequences the APB side of the bridge environment and shares one APB bus among REQS local requesters.
- Arbitrates requests round-robin and decodes the address to a one-hot Pselx.
- Drives the two-phase APB transfer (SETUP, then ACCESS), captures Prdata and returns a response to the granted requester.
- Sits between the requester ports and an apb_if-style bus: Penable, Pwrite, Pwdata, Prdata, Paddr, Pselx. There is no Pready; transfers have no wait states.

---
 rtl/apb_rr_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/apb_rr_master.sv
// APB master shared by REQS requesters: round-robin arbitration, top-byte slave decode,
// and a zero-wait-state SETUP/ACCESS sequence with a registered one-cycle response strobe.
module apb_rr_master #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SLAVES = 3,
    parameter int unsigned REQS   = 2
) (
    input  logic                   Hclk,
    input  logic                   Hresetn,
    input  logic [REQS-1:0]        req_valid,
    input  logic [REQS-1:0]        req_write,
    input  logic [REQS*WIDTH-1:0]  req_addr,
    input  logic [REQS*WIDTH-1:0]  req_wdata,
    output logic [REQS-1:0]        req_ready,
    output logic [REQS-1:0]        rsp_valid,
    output logic [WIDTH-1:0]       rsp_rdata,
    output logic                   rsp_err,
    output logic                   Penable,
    output logic                   Pwrite,
    output logic [WIDTH-1:0]       Paddr,
    output logic [WIDTH-1:0]       Pwdata,
    output logic [SLAVES-1:0]      Pselx,
    input  logic [WIDTH-1:0]       Prdata
);

    localparam int unsigned PW = $clog2(REQS);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      gnt_q, gnt_d;
    logic               Penable_q, Penable_d;
    logic               Pwrite_q, Pwrite_d;
    logic [WIDTH-1:0]   Paddr_q, Paddr_d;
    logic [WIDTH-1:0]   Pwdata_q, Pwdata_d;
    logic [SLAVES-1:0]  Pselx_q, Pselx_d;
    logic [REQS-1:0]    rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic               found;
    logic [PW-1:0]      win;
    logic [PW-1:0]      idx;
    logic [WIDTH-1:0]   win_addr;
    logic [WIDTH-1:0]   win_wdata;
    logic               win_write;
    logic [7:0]         win_top;
    logic [SLAVES-1:0]  dec_sel;
    logic               hit;
    logic [REQS-1:0]    ready_c;

    // First valid requester at or above the pointer, wrapping mod REQS.
    always_comb begin
        found     = 1'b0;
        win       = '0;
        idx       = '0;
        win_addr  = '0;
        win_wdata = '0;
        win_write = 1'b0;
        for (int unsigned k = 0; k < REQS; k++) begin
            idx = PW'((32'(ptr_q) + k) % REQS);
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                win       = idx;
                win_addr  = req_addr[idx*WIDTH +: WIDTH];
                win_wdata = req_wdata[idx*WIDTH +: WIDTH];
                win_write = req_write[idx];
            end
        end
    end

    always_comb begin
        win_top = win_addr[WIDTH-1 -: 8];
        dec_sel = '0;
        for (int unsigned i = 0; i < SLAVES; i++) begin
            dec_sel[i] = (win_top == 8'(8'h80 + i));
        end
        hit = |dec_sel;
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            Penable_q   <= 1'b0;
            Pwrite_q    <= 1'b0;
            Paddr_q     <= '0;
            Pwdata_q    <= '0;
            Pselx_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            Penable_q   <= Penable_d;
            Pwrite_q    <= Pwrite_d;
            Paddr_q     <= Paddr_d;
            Pwdata_q    <= Pwdata_d;
            Pselx_q     <= Pselx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = hit ? SETUP : ERR;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_c     = '0;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        Penable_d   = 1'b0;
        Pwrite_d    = Pwrite_q;
        Paddr_d     = Paddr_q;
        Pwdata_d    = Pwdata_q;
        Pselx_d     = Pselx_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    ready_c[win] = 1'b1;
                    ptr_d        = (win == PW'(REQS-1)) ? '0 : win + 1'b1;
                    gnt_d        = win;
                    // Bus fields are only loaded on a decode hit so they hold across errors.
                    if (hit) begin
                        Pselx_d  = dec_sel;
                        Paddr_d  = win_addr;
                        Pwrite_d = win_write;
                        Pwdata_d = win_wdata;
                    end
                end
            end
            SETUP: Penable_d = 1'b1;
            ACCESS: begin
                Pselx_d            = '0;
                rsp_valid_d[gnt_q] = 1'b1;
                rsp_err_d          = 1'b0;
                rsp_rdata_d        = Pwrite_q ? '0 : Prdata;
            end
            ERR: begin
                rsp_valid_d[gnt_q] = 1'b1;
                rsp_err_d          = 1'b1;
                rsp_rdata_d        = '0;
            end
            default: ;
        endcase
    end

    assign req_ready = ready_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign Penable   = Penable_q;
    assign Pwrite    = Pwrite_q;
    assign Paddr     = Paddr_q;
    assign Pwdata    = Pwdata_q;
    assign Pselx     = Pselx_q;

endmodule
